// File: rtl/gates7_bist.sv
// Built-in self-test controller for the seven-gate block: sweeps the four {b,a}
// vectors, checks every gate output against its truth table and keeps a result summary.
module gates7_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             f_and,
  input  logic             f_or,
  input  logic             f_not,
  input  logic             f_nand,
  input  logic             f_nor,
  input  logic             f_xor,
  input  logic             f_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t             state;
  logic [1:0]         v;
  logic [1:0]         v_inc;
  logic [SW-1:0]      settle_cnt;
  logic [PW-1:0]      pass_cnt;
  logic [6:0]         observed;
  logic [6:0]         mismatch;
  logic               any_mis;
  logic               last_check;
  logic [ERR_W-1:0]   err_next;

  // Bit order matches fail_mask: and, or, not, nand, nor, xor, xnor.
  function automatic logic [6:0] golden_of(input logic ga, input logic gb);
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ~ga, ga | gb, ga & gb};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + ERR_W'(1);
  endfunction

  always_comb begin
    observed   = {f_xnor, f_xor, f_nor, f_nand, f_not, f_or, f_and};
    mismatch   = golden_of(a, b) ^ observed;
    any_mis    = |mismatch;
    v_inc      = v + 2'd1;
    last_check = (v == 2'd3) && (pass_cnt == PW'(PASSES - 1));
    err_next   = any_mis ? sat_inc(err_count) : err_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      v                <= 2'd0;
      settle_cnt       <= '0;
      pass_cnt         <= '0;
      a                <= 1'b0;
      b                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      fail_mask        <= 7'd0;
      first_fail_vec   <= 2'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= APPLY;
            v                <= 2'd0;
            settle_cnt       <= '0;
            pass_cnt         <= '0;
            a                <= 1'b0;
            b                <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_mask        <= 7'd0;
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
          end
        end
        APPLY: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        CHECK: begin
          fail_mask <= fail_mask | mismatch;
          err_count <= err_next;
          if (any_mis && !first_fail_valid) begin
            first_fail_vec   <= {b, a};
            first_fail_valid <= 1'b1;
          end
          if (last_check) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            // a/b move to the next vector together with v so they are held for the full APPLY window.
            if (v == 2'd3) pass_cnt <= pass_cnt + PW'(1);
            v     <= v_inc;
            a     <= v_inc[0];
            b     <= v_inc[1];
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gates7_bist.sv
// Bench for gates7_bist: three parameterisations driven by a fault-injectable gate model,
// table rows with hand-derived results plus randomised faults against a behavioural model.
module tb_gates7_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s [3];
  logic       a_s     [3];
  logic       b_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       pass_s  [3];
  logic       ffv_s   [3];
  logic [6:0] mask_s  [3];
  logic [1:0] ffvec_s [3];
  logic [6:0] f_s     [3];
  logic [6:0] stkm    [3];
  logic [6:0] stkv    [3];
  logic [6:0] inv     [3];
  logic [3:0] err0, err2;
  logic [1:0] err1;

  int settle_p [3] = '{1, 1, 3};
  int passes_p [3] = '{1, 2, 1};
  int errw_p   [3] = '{4, 2, 4};

  int n_cmp = 0;
  int n_bad = 0;

  // Truth table from counting ones: s = number of inputs high, p = both high.
  function automatic logic [6:0] truth(input logic ta, input logic tb);
    int ia, ib;
    logic [6:0] t;
    ia = ta ? 1 : 0;
    ib = tb ? 1 : 0;
    t[0] = (ia * ib) == 1;
    t[1] = (ia + ib) > 0;
    t[2] = ia == 0;
    t[3] = (ia * ib) == 0;
    t[4] = (ia + ib) == 0;
    t[5] = (ia + ib) == 1;
    t[6] = (ia + ib) != 1;
    return t;
  endfunction

  function automatic logic [6:0] faulty(input logic ta, input logic tb,
                                        input logic [6:0] m, input logic [6:0] sv,
                                        input logic [6:0] iv);
    return ((truth(ta, tb) ^ iv) & ~m) | (m & sv);
  endfunction

  assign f_s[0] = faulty(a_s[0], b_s[0], stkm[0], stkv[0], inv[0]);
  assign f_s[1] = faulty(a_s[1], b_s[1], stkm[1], stkv[1], inv[1]);
  assign f_s[2] = faulty(a_s[2], b_s[2], stkm[2], stkv[2], inv[2]);

  gates7_bist #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .f_and(f_s[0][0]), .f_or(f_s[0][1]), .f_not(f_s[0][2]), .f_nand(f_s[0][3]),
    .f_nor(f_s[0][4]), .f_xor(f_s[0][5]), .f_xnor(f_s[0][6]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err0),
    .fail_mask(mask_s[0]), .first_fail_vec(ffvec_s[0]), .first_fail_valid(ffv_s[0]));

  gates7_bist #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .f_and(f_s[1][0]), .f_or(f_s[1][1]), .f_not(f_s[1][2]), .f_nand(f_s[1][3]),
    .f_nor(f_s[1][4]), .f_xor(f_s[1][5]), .f_xnor(f_s[1][6]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err1),
    .fail_mask(mask_s[1]), .first_fail_vec(ffvec_s[1]), .first_fail_valid(ffv_s[1]));

  gates7_bist #(.SETTLE_CYCLES(3), .PASSES(1), .ERR_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .f_and(f_s[2][0]), .f_or(f_s[2][1]), .f_not(f_s[2][2]), .f_nand(f_s[2][3]),
    .f_nor(f_s[2][4]), .f_xor(f_s[2][5]), .f_xnor(f_s[2][6]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err2),
    .fail_mask(mask_s[2]), .first_fail_vec(ffvec_s[2]), .first_fail_valid(ffv_s[2]));

  function automatic int get_err(input int k);
    if (k == 0) return int'(err0);
    if (k == 1) return int'(err1);
    return int'(err2);
  endfunction

  function automatic int ctl(input int k);
    return int'({busy_s[k], done_s[k], b_s[k], a_s[k]});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: walk passes x vectors, count failing vectors with a ceiling.
  task automatic model(input int k, output int e_err, output logic [6:0] e_mask,
                       output logic [1:0] e_fv, output logic e_ffv);
    int cap;
    logic [6:0] diff;
    logic ta, tb;
    cap = (1 << errw_p[k]) - 1;
    e_err = 0; e_mask = 7'd0; e_fv = 2'd0; e_ffv = 1'b0;
    for (int p = 0; p < passes_p[k]; p++) begin
      for (int vv = 0; vv < 4; vv++) begin
        ta = (vv % 2) == 1;
        tb = (vv / 2) == 1;
        diff = truth(ta, tb) ^ faulty(ta, tb, stkm[k], stkv[k], inv[k]);
        if (diff != 7'd0) begin
          if (e_err < cap) e_err++;
          e_mask |= diff;
          if (!e_ffv) begin
            e_fv  = {tb, ta};
            e_ffv = 1'b1;
          end
        end
      end
    end
  endtask

  // One run from IDLE or DONE; stray >= 0 pulses start while busy after that edge.
  task automatic run(input int k, input int stray, input int x_err, input logic [6:0] x_mask,
                     input logic [1:0] x_fv, input logic x_ffv, input string tag);
    int hold, total;
    hold  = settle_p[k] + 1;
    total = 4 * passes_p[k] * hold;
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    for (int j = 0; j < total; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        start_s[k] = 1'b0;
      end
      chk($sformatf("%s ctl e%0d", tag, j), ctl(k), 8 + ((j / hold) % 4));
      if (j == stray) start_s[k] = 1'b1;
    end
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    chk($sformatf("%s ctl e%0d done", tag, total), ctl(k), 7);
    chk({tag, " err_count"}, get_err(k), x_err);
    chk({tag, " fail_mask"}, int'(mask_s[k]), int'(x_mask));
    chk({tag, " ffv"}, int'(ffv_s[k]), int'(x_ffv));
    if (x_ffv) chk({tag, " first_fail_vec"}, int'(ffvec_s[k]), int'(x_fv));
    chk({tag, " pass"}, int'(pass_s[k]), (x_err == 0) ? 1 : 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " hold ctl"}, ctl(k), 7);
    chk({tag, " hold err"}, get_err(k), x_err);
  endtask

  typedef struct {
    int         k;
    logic [6:0] m;
    logic [6:0] sv;
    logic [6:0] iv;
    int         stray;
    int         err;
    logic [6:0] mask;
    logic [1:0] fv;
    logic       ffv;
  } row_t;

  row_t tbl [7];

  initial begin
    int r_err, stray, total;
    logic [6:0] r_mask;
    logic [1:0] r_fv;
    logic r_ffv;

    tbl[0] = '{0, 7'h00, 7'h00, 7'h00, -1, 0, 7'b0000000, 2'b00, 1'b0};
    tbl[1] = '{0, 7'b0100000, 7'h00, 7'h00, -1, 2, 7'b0100000, 2'b01, 1'b1};
    tbl[2] = '{0, 7'h00, 7'h00, 7'b0000100, -1, 4, 7'b0000100, 2'b00, 1'b1};
    tbl[3] = '{1, 7'b0000001, 7'b0000001, 7'h00, 3, 3, 7'b0000001, 2'b00, 1'b1};
    tbl[4] = '{2, 7'h00, 7'h00, 7'h00, -1, 0, 7'b0000000, 2'b00, 1'b0};
    tbl[5] = '{2, 7'b0010000, 7'b0010000, 7'h00, 5, 3, 7'b0010000, 2'b01, 1'b1};
    tbl[6] = '{0, 7'b1000000, 7'h00, 7'h00, 2, 2, 7'b1000000, 2'b00, 1'b1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; stkm[k] = 7'd0; stkv[k] = 7'd0; inv[k] = 7'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset ctl u%0d", k), ctl(k), 0);
      chk($sformatf("reset pass u%0d", k), int'(pass_s[k]), 0);
      chk($sformatf("reset err u%0d", k), get_err(k), 0);
      chk($sformatf("reset mask u%0d", k), int'(mask_s[k]), 0);
      chk($sformatf("reset ffv u%0d", k), int'(ffv_s[k]), 0);
      chk($sformatf("reset fvec u%0d", k), int'(ffvec_s[k]), 0);
    end

    for (int i = 0; i < 7; i++) begin
      stkm[tbl[i].k] = tbl[i].m;
      stkv[tbl[i].k] = tbl[i].sv;
      inv[tbl[i].k]  = tbl[i].iv;
      run(tbl[i].k, tbl[i].stray, tbl[i].err, tbl[i].mask, tbl[i].fv, tbl[i].ffv,
          $sformatf("row%0d", i));
    end
    // Back-to-back restart from DONE on the slow-settle instance must repeat identically.
    run(2, -1, 3, 7'b0010000, 2'b01, 1'b1, "row5 again");

    // Mid-run reset with an ignored start earlier in the run.
    stkm[0] = 7'b0100000; stkv[0] = 7'd0; inv[0] = 7'd0;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("rstseq ctl e2", ctl(0), 9);
    repeat (2) @(posedge clk);
    #1;
    chk("rstseq err e4", get_err(0), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstseq ctl after rst", ctl(0), 0);
    chk("rstseq err after rst", get_err(0), 0);
    chk("rstseq mask after rst", int'(mask_s[0]), 0);
    chk("rstseq ffv after rst", int'(ffv_s[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstseq stays idle", ctl(0), 0);
    stkm[0] = 7'd0;
    run(0, -1, 0, 7'd0, 2'b00, 1'b0, "rstseq clean");

    // Randomised faults against the behavioural model.
    for (int i = 0; i < 10; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      stkm[k] = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      stkv[k] = 7'($urandom_range(0, 127));
      inv[k]  = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      total = 4 * passes_p[k] * (settle_p[k] + 1);
      stray = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, total - 2));
      model(k, r_err, r_mask, r_fv, r_ffv);
      run(k, stray, r_err, r_mask, r_fv, r_ffv, $sformatf("rand%0d u%0d", i, k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gates7_bist.md
Name: gates7_bist

Overview:
- Self-test controller for the seven-gate dataflow block (inputs a, b; outputs and/or/not/nand/nor/xor/xnor).
- Sits directly upstream of that block, driving its a and b, and directly downstream of it, sampling its seven outputs.
- Sweeps all four input vectors, compares each output against the golden truth table, and reports pass/fail, an error count, a per-gate fail mask and the first failing vector.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before sampling (legal range >= 1)
PASSES, 1, number of full 4-vector sweeps per run (legal range >= 1)
ERR_W, 4, width of the saturating error counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  run request, sampled only in IDLE or DONE
a  out  1  gate input a, registered
b  out  1  gate input b, registered
f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor  in  1 each  gate-block outputs (combinational from a, b)
busy  out  1  run in progress
done  out  1  run finished; results valid
pass  out  1  done and err_count==0
err_count  out  ERR_W  vectors with >=1 mismatching gate, saturating at 2^ERR_W-1
fail_mask  out  7  sticky per-gate mismatch flags; bit0 and, 1 or, 2 not, 3 nand, 4 nor, 5 xor, 6 xnor
first_fail_vec  out  2  {b,a} of the first failing vector
first_fail_valid  out  1  first_fail_vec holds a captured value

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state IDLE; a, b, busy, done, pass, first_fail_valid = 0; err_count, fail_mask, first_fail_vec = 0. Reset applied mid-run aborts the run the following cycle with no partial results kept.
- Vector order: 2-bit vector counter v; a = v[0], b = v[1]. Sequence {a,b} = 00, 10, 01, 11.
- Golden outputs: and = a&b; or = a|b; not = ~a; nand = ~(a&b); nor = ~(a|b); xor = a^b; xnor = ~(a^b).
- IDLE -> APPLY when start=1:
  - v, settle counter and pass counter cleared.
  - err_count, fail_mask and first_fail_valid cleared.
  - busy=1, done=0, pass=0.
- APPLY:
  - a, b driven from v.
  - Held for SETTLE_CYCLES cycles, then -> CHECK.
- CHECK (exactly 1 cycle):
  - The seven f_* inputs are compared against the golden values of the current a, b at the clock edge that ends CHECK.
  - Mismatch bits are ORed into fail_mask.
  - If any bit mismatches: err_count += 1 (saturating; never wraps).
  - If any bit mismatches and first_fail_valid=0: first_fail_vec = {b,a}, first_fail_valid = 1.
  - If v==3 and pass counter == PASSES-1: -> DONE.
  - Otherwise v wraps 3 -> 0 (pass counter +1) or increments, -> APPLY.
- DONE:
  - busy=0, done=1, pass = (err_count==0).
  - a, b hold the last vector (1,1).
  - Results hold until start or rst.
  - start in DONE behaves exactly as start in IDLE: results are cleared and done drops the next cycle.
- start while busy: ignored, with no effect on state or results.
- Latency: done rises at the 4·PASSES·(SETTLE_CYCLES+1)-th rising edge after the edge that sampled start. Defaults: edge 8.
- Counting granularity: err_count counts failing vectors (per check), not failing gates.
- Registered outputs: all outputs are registered; no combinational path from f_* to any output.

Test Plan:
1. Fault-free gate model, defaults, 1-cycle start pulse:
   - {a,b} = 00, 10, 01, 11, each held 2 cycles.
   - busy high for edges 1-8; done=1 at edge 8.
   - pass=1, err_count=0, fail_mask=0, first_fail_valid=0.
2. f_xor stuck-at-0, defaults:
   - Mismatches at vectors a=1,b=0 and a=0,b=1.
   - err_count=2, fail_mask=7'b0100000, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
3. f_not inverted (wrong on all vectors):
   - err_count=4, fail_mask=7'b0000100, first_fail_vec=2'b00, pass=0.
4. ERR_W=2, PASSES=2, f_and stuck-at-1:
   - 6 failing checks; err_count saturates at 3, never 0.
   - fail_mask=7'b0000001; done at edge 16.
5. rst asserted at edge 5 of a run:
   - At the next edge: busy=0, a=b=0, err_count=0, state IDLE.
   - start pulsed during an earlier busy cycle had no effect.
   - A fresh start afterwards completes clean with pass=1 at edge 8.
6. SETTLE_CYCLES=3, fault-free:
   - Each vector held 4 cycles; done at edge 16.
   - start in DONE clears done/pass the next cycle and repeats identically.
